// File: rtl/voice_alloc_pkg.sv
// Shared types, pitch table and width helpers for the voice allocator.
package voice_alloc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RELEASE,
        ALLOCATE,
        GAP
    } state_e;

    typedef enum logic [1:0] {
        RANK_HOLD,
        RANK_ALLOC,
        RANK_FREE
    } rank_op_e;

    localparam int HZ_TABLE_LEN = 8;

    localparam logic [31:0] HZ_TABLE [HZ_TABLE_LEN] = '{
        32'd191109, 32'd170265, 32'd151685, 32'd143172,
        32'd127551, 32'd113636, 32'd101239, 32'd95556
    };

    function automatic int key_w(input int num_keys);
        return (num_keys > 1) ? $clog2(num_keys) : 1;
    endfunction

    function automatic int rank_w(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

    function automatic logic [31:0] hz_of(input int k);
        return HZ_TABLE[k % HZ_TABLE_LEN];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key switch levels.
module key_sync #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/voice_allocator.sv
// Shares a small bank of wave-generator voices among many key switches.
// Define VOICE_STEAL_EN to steal the least recently allocated voice when full.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int  NUM_KEYS   = 8,
    parameter int  NUM_VOICES = 4,
    parameter int  HZ_W       = 32,
    localparam int KW         = key_w(NUM_KEYS),
    localparam int VW         = rank_w(NUM_VOICES)
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [NUM_KEYS-1:0]        key_on,
    output logic [NUM_VOICES-1:0]      voice_play,
    output logic [NUM_VOICES*HZ_W-1:0] voice_hz,
    output logic [NUM_VOICES*KW-1:0]   voice_key,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] pend_on, pend_off, pend;
    logic [NUM_KEYS-1:0] key_alloc_q, key_alloc_d;
    logic [NUM_KEYS-1:0] key_lost_q, key_lost_d;

    logic [KW-1:0] rr_ptr_q, rr_ptr_d;
    logic [KW-1:0] sel_q, sel_d;
    logic [KW-1:0] pick, scan;
    logic          pick_ok;

    state_e state_q, state_d;

    logic [NUM_VOICES-1:0]           voice_play_q, voice_play_d;
    logic [NUM_VOICES-1:0][HZ_W-1:0] voice_hz_q, voice_hz_d;
    logic [NUM_VOICES-1:0][KW-1:0]   voice_key_q, voice_key_d;
    logic [NUM_VOICES-1:0][VW-1:0]   voice_rank_q, voice_rank_d;
    logic [7:0]                      drop_cnt_q, drop_cnt_d;

    logic [VW-1:0] free_v, rel_v, rank_v;
    logic          free_ok, rel_ok;
    rank_op_e      rank_op;

    key_sync #(
        .W(NUM_KEYS)
    ) u_sync (
        .clock (clock),
        .resetn(resetn),
        .d     (key_on),
        .q     (key_held)
    );

    // Descending scan so the smallest offset from rr_ptr wins.
    always_comb begin
        pend_on  = key_held & ~key_alloc_q & ~key_lost_q;
        pend_off = ~key_held & key_alloc_q;
        pend     = pend_on | pend_off;
        pick_ok  = 1'b0;
        pick     = '0;
        scan     = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            scan = rr_ptr_q + KW'(i);
            if (pend[scan]) begin
                pick_ok = 1'b1;
                pick    = scan;
            end
        end
    end

    always_comb begin
        free_ok = 1'b0;
        free_v  = '0;
        rel_ok  = 1'b0;
        rel_v   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_play_q[v]) begin
                free_ok = 1'b1;
                free_v  = VW'(v);
            end
            if (voice_play_q[v] && voice_key_q[v] == sel_q) begin
                rel_ok = 1'b1;
                rel_v  = VW'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [VW-1:0] victim_q, victim_d, lru_v;

    // Only consulted when every voice is active; ranks are then distinct.
    always_comb begin
        lru_v = '0;
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (voice_rank_q[v] > voice_rank_q[lru_v]) begin
                lru_v = VW'(v);
            end
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        rr_ptr_d     = rr_ptr_q;
        key_alloc_d  = key_alloc_q;
        key_lost_d   = key_lost_q & key_held;
        voice_play_d = voice_play_q;
        voice_hz_d   = voice_hz_q;
        voice_key_d  = voice_key_q;
        drop_cnt_d   = drop_cnt_q;
        rank_op      = RANK_HOLD;
        rank_v       = '0;
`ifdef VOICE_STEAL_EN
        victim_d     = victim_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    sel_d    = pick;
                    rr_ptr_d = pick + KW'(1);
                    state_d  = pend_off[pick] ? RELEASE : ALLOCATE;
                end
            end
            RELEASE: begin
                if (rel_ok) begin
                    voice_play_d[rel_v] = 1'b0;
                    rank_op             = RANK_FREE;
                    rank_v              = rel_v;
                end
                key_alloc_d[sel_q] = 1'b0;
                state_d            = IDLE;
            end
            ALLOCATE: begin
                state_d = IDLE;
                if (free_ok) begin
                    voice_play_d[free_v] = 1'b1;
                    voice_hz_d[free_v]   = HZ_W'(hz_of(int'(sel_q)));
                    voice_key_d[free_v]  = sel_q;
                    key_alloc_d[sel_q]   = 1'b1;
                    rank_op              = RANK_ALLOC;
                    rank_v               = free_v;
                end else begin
`ifdef VOICE_STEAL_EN
                    key_alloc_d[voice_key_q[lru_v]] = 1'b0;
                    key_lost_d[voice_key_q[lru_v]]  = 1'b1;
                    voice_play_d[lru_v]             = 1'b0;
                    voice_hz_d[lru_v]               = HZ_W'(hz_of(int'(sel_q)));
                    voice_key_d[lru_v]              = sel_q;
                    victim_d                        = lru_v;
                    state_d                         = GAP;
`else
                    key_lost_d[sel_q] = 1'b1;
`endif
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
            end
`ifdef VOICE_STEAL_EN
            GAP: begin
                voice_play_d[victim_q] = 1'b1;
                key_alloc_d[sel_q]     = 1'b1;
                rank_op                = RANK_ALLOC;
                rank_v                 = victim_q;
                state_d                = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Active ranks stay packed 0..n-1, so the oldest voice holds the top rank.
    always_comb begin
        voice_rank_d = voice_rank_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (VW'(v) != rank_v && voice_play_q[v]) begin
                if (rank_op == RANK_ALLOC && voice_rank_q[v] != '1) begin
                    voice_rank_d[v] = voice_rank_q[v] + VW'(1);
                end
                if (rank_op == RANK_FREE && voice_rank_q[v] > voice_rank_q[rank_v]) begin
                    voice_rank_d[v] = voice_rank_q[v] - VW'(1);
                end
            end
        end
        if (rank_op == RANK_ALLOC) begin
            voice_rank_d[rank_v] = '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            rr_ptr_q     <= '0;
            key_alloc_q  <= '0;
            key_lost_q   <= '0;
            voice_play_q <= '0;
            voice_hz_q   <= '0;
            voice_key_q  <= '0;
            voice_rank_q <= '0;
            drop_cnt_q   <= '0;
`ifdef VOICE_STEAL_EN
            victim_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            rr_ptr_q     <= rr_ptr_d;
            key_alloc_q  <= key_alloc_d;
            key_lost_q   <= key_lost_d;
            voice_play_q <= voice_play_d;
            voice_hz_q   <= voice_hz_d;
            voice_key_q  <= voice_key_d;
            voice_rank_q <= voice_rank_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef VOICE_STEAL_EN
            victim_q     <= victim_d;
`endif
        end
    end

    assign voice_play = voice_play_q;
    assign voice_hz   = voice_hz_q;
    assign voice_key  = voice_key_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule
